// File: rtl/mem_dsram_master.sv
// Memory-stage master for the data SRAM-like (req/addr_ok/data_ok) bus.
// Checks alignment, issues one load/store at a time, and extends load data
// for MEM/WB. The pipeline is stalled while an access is in flight. A
// response orphaned by an exception flush is drained before the next access.
module mem_dsram_master (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        mem_en,
    input  logic [2:0]  mem_op,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic        mem_adv,
    output logic        data_sram_req,
    output logic        data_sram_wr,
    output logic [1:0]  data_sram_size,
    output logic [31:0] data_sram_addr,
    output logic [3:0]  data_sram_wstrb,
    output logic [31:0] data_sram_wdata,
    input  logic        data_sram_addr_ok,
    input  logic        data_sram_data_ok,
    input  logic [31:0] data_sram_rdata,
    output logic [31:0] dm_rdata,
    output logic        mem_stall,
    output logic        exc_adel,
    output logic        exc_ades
);

    localparam logic [2:0] OP_LB  = 3'd0;
    localparam logic [2:0] OP_LBU = 3'd1;
    localparam logic [2:0] OP_LH  = 3'd2;
    localparam logic [2:0] OP_LHU = 3'd3;
    localparam logic [2:0] OP_LW  = 3'd4;
    localparam logic [2:0] OP_SB  = 3'd5;
    localparam logic [2:0] OP_SH  = 3'd6;
    localparam logic [2:0] OP_SW  = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_HOLD  = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [2:0]  r_op;
    logic [1:0]  r_lane;
    logic [31:0] r_rdata;

    logic        w_is_store;
    logic        w_misalign;
    logic        w_issue;
    logic        w_resp_ok;
    logic        w_hold_cap;

    // Sign/zero extension of a raw read word using the captured op and lane.
    // Stores return zero so nothing stale reaches MEM/WB.
    function automatic logic [31:0] load_ext(input logic [2:0]  op,
                                             input logic [1:0]  lane,
                                             input logic [31:0] d);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        case (lane)
            2'd0:    b = d[7:0];
            2'd1:    b = d[15:8];
            2'd2:    b = d[23:16];
            default: b = d[31:24];
        endcase
        h = lane[1] ? d[31:16] : d[15:0];
        case (op)
            OP_LB:   res = {{24{b[7]}}, b};
            OP_LBU:  res = {24'd0, b};
            OP_LH:   res = {{16{h[15]}}, h};
            OP_LHU:  res = {16'd0, h};
            OP_LW:   res = d;
            default: res = 32'd0;
        endcase
        return res;
    endfunction

    // Decode the current MEM instruction: direction, alignment, exceptions.
    always_comb begin
        w_is_store = (mem_op == OP_SB) | (mem_op == OP_SH) | (mem_op == OP_SW);
        case (mem_op)
            OP_LH, OP_LHU, OP_SH: w_misalign = mem_addr[0];
            OP_LW, OP_SW:         w_misalign = |mem_addr[1:0];
            default:              w_misalign = 1'b0;
        endcase
        exc_adel = mem_en & w_misalign & ~w_is_store;
        exc_ades = mem_en & w_misalign & w_is_store;
        w_issue  = (r_state == S_IDLE) & mem_en & ~w_misalign & ~flush;
    end

    // Request channel: address/control come straight from the held MEM inputs.
    always_comb begin
        data_sram_req  = w_issue | ((r_state == S_REQ) & ~flush);
        data_sram_wr   = w_is_store;
        data_sram_addr = mem_addr;
        case (mem_op)
            OP_LB, OP_LBU, OP_SB: data_sram_size = 2'd0;
            OP_LH, OP_LHU, OP_SH: data_sram_size = 2'd1;
            default:              data_sram_size = 2'd2;
        endcase
        case (mem_op)
            OP_SB: begin
                data_sram_wstrb = 4'b0001 << mem_addr[1:0];
                data_sram_wdata = {4{mem_wdata[7:0]}};
            end
            OP_SH: begin
                data_sram_wstrb = 4'b0011 << mem_addr[1:0];
                data_sram_wdata = {2{mem_wdata[15:0]}};
            end
            OP_SW: begin
                data_sram_wstrb = 4'b1111;
                data_sram_wdata = mem_wdata;
            end
            default: begin
                data_sram_wstrb = 4'b0000;
                data_sram_wdata = mem_wdata;
            end
        endcase
    end

    // Next-state logic for the single outstanding transaction.
    always_comb begin
        w_state_nxt = r_state;
        w_resp_ok   = (r_state == S_WAIT) & data_sram_data_ok;
        w_hold_cap  = w_resp_ok & ~flush & ~mem_adv;
        case (r_state)
            S_IDLE: begin
                if (w_issue) w_state_nxt = data_sram_addr_ok ? S_WAIT : S_REQ;
            end
            S_REQ: begin
                if (flush)                  w_state_nxt = S_IDLE;
                else if (data_sram_addr_ok) w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (data_sram_data_ok)      w_state_nxt = (flush | mem_adv) ? S_IDLE : S_HOLD;
                else if (flush)             w_state_nxt = S_DRAIN;
            end
            S_HOLD: begin
                if (mem_adv | flush)        w_state_nxt = S_IDLE;
            end
            S_DRAIN: begin
                if (data_sram_data_ok)      w_state_nxt = S_IDLE;
            end
            default:                        w_state_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Load-extension context, captured when the request is first presented.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op   <= 3'd0;
            r_lane <= 2'd0;
        end else if (w_issue) begin
            r_op   <= mem_op;
            r_lane <= mem_addr[1:0];
        end
    end

    // Raw read data parked while MEM/WB is not ready to take it.
    always_ff @(posedge clk) begin
        if (rst)             r_rdata <= 32'd0;
        else if (w_hold_cap) r_rdata <= data_sram_rdata;
    end

    // Load result toward MEM/WB and the pipeline stall.
    always_comb begin
        dm_rdata = 32'd0;
        if (w_resp_ok)               dm_rdata = load_ext(r_op, r_lane, data_sram_rdata);
        else if (r_state == S_HOLD)  dm_rdata = load_ext(r_op, r_lane, r_rdata);
        mem_stall = (mem_en & ~w_misalign & ~flush & ~(w_resp_ok | (r_state == S_HOLD)))
                  | ((r_state == S_DRAIN) & mem_en);
    end

endmodule

// File: tb/tb_mem_dsram_master.sv
// Directed, table-driven bench for mem_dsram_master.
module tb_mem_dsram_master;

    logic        clk = 1'b0;
    logic        rst, flush, mem_en, mem_adv;
    logic [2:0]  mem_op;
    logic [31:0] mem_addr, mem_wdata;
    logic        data_sram_req, data_sram_wr;
    logic [1:0]  data_sram_size;
    logic [31:0] data_sram_addr;
    logic [3:0]  data_sram_wstrb;
    logic [31:0] data_sram_wdata;
    logic        data_sram_addr_ok, data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic [31:0] dm_rdata;
    logic        mem_stall, exc_adel, exc_ades;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mem_dsram_master dut (
        .clk(clk), .rst(rst), .flush(flush), .mem_en(mem_en), .mem_op(mem_op),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_adv(mem_adv),
        .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
        .data_sram_size(data_sram_size), .data_sram_addr(data_sram_addr),
        .data_sram_wstrb(data_sram_wstrb), .data_sram_wdata(data_sram_wdata),
        .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
        .data_sram_rdata(data_sram_rdata), .dm_rdata(dm_rdata),
        .mem_stall(mem_stall), .exc_adel(exc_adel), .exc_ades(exc_ades)
    );

    typedef struct {
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        mis;
        logic [1:0]  size;
        logic [3:0]  wstrb;
        logic [31:0] exp_wdata;
        logic [31:0] exp_dm;
    } vec_t;

    vec_t vt[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic bus_idle();
        mem_en = 0; flush = 0; mem_adv = 0;
        data_sram_addr_ok = 0; data_sram_data_ok = 0; data_sram_rdata = 32'h0;
    endtask

    task automatic set_instr(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd);
        mem_en = 1; mem_op = op; mem_addr = addr; mem_wdata = wd;
    endtask

    initial begin
        rst = 1; mem_op = 0; mem_addr = 0; mem_wdata = 0;
        bus_idle();

        vt[0]  = '{3'd4, 32'h100, 32'h0,        32'hDEADBEEF, 1'b0, 2'd2, 4'b0000, 32'h0,        32'hDEADBEEF};
        vt[1]  = '{3'd0, 32'h103, 32'h0,        32'h80FF7F01, 1'b0, 2'd0, 4'b0000, 32'h0,        32'hFFFFFF80};
        vt[2]  = '{3'd1, 32'h103, 32'h0,        32'h80FF7F01, 1'b0, 2'd0, 4'b0000, 32'h0,        32'h00000080};
        vt[3]  = '{3'd2, 32'h102, 32'h0,        32'h80FF7F01, 1'b0, 2'd1, 4'b0000, 32'h0,        32'hFFFF80FF};
        vt[4]  = '{3'd3, 32'h100, 32'h0,        32'h80FF7F01, 1'b0, 2'd1, 4'b0000, 32'h0,        32'h00007F01};
        vt[5]  = '{3'd0, 32'h101, 32'h0,        32'h80FF7F01, 1'b0, 2'd0, 4'b0000, 32'h0,        32'h0000007F};
        vt[6]  = '{3'd5, 32'h201, 32'h123456AB, 32'h77777777, 1'b0, 2'd0, 4'b0010, 32'hABABABAB, 32'h0};
        vt[7]  = '{3'd6, 32'h202, 32'hFFFF1234, 32'h77777777, 1'b0, 2'd1, 4'b1100, 32'h12341234, 32'h0};
        vt[8]  = '{3'd7, 32'h204, 32'hCAFEF00D, 32'h77777777, 1'b0, 2'd2, 4'b1111, 32'hCAFEF00D, 32'h0};
        vt[9]  = '{3'd6, 32'h203, 32'h0,        32'h0,        1'b1, 2'd1, 4'b0000, 32'h0,        32'h0};
        vt[10] = '{3'd4, 32'h102, 32'h0,        32'h0,        1'b1, 2'd2, 4'b0000, 32'h0,        32'h0};
        vt[11] = '{3'd2, 32'h101, 32'h0,        32'h0,        1'b1, 2'd1, 4'b0000, 32'h0,        32'h0};

        // Reset state
        tick(); tick();
        sample();
        chk("rst_req", {31'd0, data_sram_req}, 32'd0);
        chk("rst_dm", dm_rdata, 32'd0);
        chk("rst_stall", {31'd0, mem_stall}, 32'd0);
        tick();
        rst = 0;
        sample();
        chk("post_rst_req", {31'd0, data_sram_req}, 32'd0);
        tick();

        // Table: one best-case transaction per record
        for (int i = 0; i < 12; i++) begin
            set_instr(vt[i].op, vt[i].addr, vt[i].wdata);
            data_sram_addr_ok = 1;
            sample();
            chk($sformatf("v%0d_adel", i), {31'd0, exc_adel}, {31'd0, vt[i].mis & (vt[i].op < 3'd5)});
            chk($sformatf("v%0d_ades", i), {31'd0, exc_ades}, {31'd0, vt[i].mis & (vt[i].op >= 3'd5)});
            if (vt[i].mis) begin
                chk($sformatf("v%0d_req", i), {31'd0, data_sram_req}, 32'd0);
                chk($sformatf("v%0d_stall", i), {31'd0, mem_stall}, 32'd0);
                tick();
                sample();
                chk($sformatf("v%0d_req2", i), {31'd0, data_sram_req}, 32'd0);
                chk($sformatf("v%0d_stall2", i), {31'd0, mem_stall}, 32'd0);
                tick();
            end else begin
                chk($sformatf("v%0d_req", i), {31'd0, data_sram_req}, 32'd1);
                chk($sformatf("v%0d_wr", i), {31'd0, data_sram_wr}, {31'd0, vt[i].op >= 3'd5});
                chk($sformatf("v%0d_size", i), {30'd0, data_sram_size}, {30'd0, vt[i].size});
                chk($sformatf("v%0d_addr", i), data_sram_addr, vt[i].addr);
                chk($sformatf("v%0d_wstrb", i), {28'd0, data_sram_wstrb}, {28'd0, vt[i].wstrb});
                if (vt[i].op >= 3'd5)
                    chk($sformatf("v%0d_wdata", i), data_sram_wdata, vt[i].exp_wdata);
                chk($sformatf("v%0d_stall0", i), {31'd0, mem_stall}, 32'd1);
                tick();
                data_sram_addr_ok = 0; data_sram_data_ok = 1; mem_adv = 1;
                data_sram_rdata = vt[i].rdata;
                sample();
                chk($sformatf("v%0d_dm", i), dm_rdata, vt[i].exp_dm);
                chk($sformatf("v%0d_stall1", i), {31'd0, mem_stall}, 32'd0);
                chk($sformatf("v%0d_req1", i), {31'd0, data_sram_req}, 32'd0);
                tick();
            end
            bus_idle();
            sample();
            chk($sformatf("v%0d_dm_idle", i), dm_rdata, 32'd0);
            tick();
        end

        // Late addr_ok (3 cycles), late data_ok (2 cycles), no mem_adv -> HOLD
        set_instr(3'd2, 32'h102, 32'h0);
        for (int c = 0; c < 3; c++) begin
            sample();
            chk($sformatf("late_req_c%0d", c), {31'd0, data_sram_req}, 32'd1);
            chk($sformatf("late_stall_c%0d", c), {31'd0, mem_stall}, 32'd1);
            tick();
        end
        data_sram_addr_ok = 1;
        sample();
        chk("late_req_acc", {31'd0, data_sram_req}, 32'd1);
        tick();
        data_sram_addr_ok = 0;
        sample();
        chk("late_wait_req", {31'd0, data_sram_req}, 32'd0);
        chk("late_wait_stall", {31'd0, mem_stall}, 32'd1);
        chk("late_wait_dm", dm_rdata, 32'd0);
        tick();
        sample();
        chk("late_wait2_stall", {31'd0, mem_stall}, 32'd1);
        tick();
        data_sram_data_ok = 1; data_sram_rdata = 32'h80FF7F01;
        sample();
        chk("late_dok_dm", dm_rdata, 32'hFFFF80FF);
        chk("late_dok_stall", {31'd0, mem_stall}, 32'd0);
        tick();
        data_sram_data_ok = 0; data_sram_rdata = 32'h00000000;
        sample();
        chk("hold_dm", dm_rdata, 32'hFFFF80FF);
        chk("hold_stall", {31'd0, mem_stall}, 32'd0);
        chk("hold_req", {31'd0, data_sram_req}, 32'd0);
        tick();
        sample();
        chk("hold2_dm", dm_rdata, 32'hFFFF80FF);
        tick();
        mem_adv = 1;
        sample();
        chk("hold_adv_dm", dm_rdata, 32'hFFFF80FF);
        tick();
        bus_idle();
        sample();
        chk("hold_exit_dm", dm_rdata, 32'd0);
        tick();

        // Flush in WAIT before data_ok -> DRAIN, next LW blocked until stale data_ok
        set_instr(3'd4, 32'h100, 32'h0);
        data_sram_addr_ok = 1;
        tick();
        data_sram_addr_ok = 0; flush = 1;
        sample();
        chk("fl_wait_req", {31'd0, data_sram_req}, 32'd0);
        chk("fl_wait_stall", {31'd0, mem_stall}, 32'd0);
        tick();
        flush = 0;
        set_instr(3'd4, 32'h300, 32'h0);
        data_sram_addr_ok = 1;
        for (int c = 0; c < 2; c++) begin
            sample();
            chk($sformatf("drain_stall_c%0d", c), {31'd0, mem_stall}, 32'd1);
            chk($sformatf("drain_req_c%0d", c), {31'd0, data_sram_req}, 32'd0);
            tick();
        end
        data_sram_addr_ok = 0; data_sram_data_ok = 1; data_sram_rdata = 32'h11111111;
        sample();
        chk("drain_dok_stall", {31'd0, mem_stall}, 32'd1);
        chk("drain_dok_req", {31'd0, data_sram_req}, 32'd0);
        chk("drain_dok_dm", dm_rdata, 32'd0);
        tick();
        data_sram_data_ok = 0; data_sram_addr_ok = 1;
        sample();
        chk("after_drain_req", {31'd0, data_sram_req}, 32'd1);
        chk("after_drain_addr", data_sram_addr, 32'h300);
        tick();
        data_sram_addr_ok = 0; data_sram_data_ok = 1; data_sram_rdata = 32'h55AA55AA; mem_adv = 1;
        sample();
        chk("after_drain_dm", dm_rdata, 32'h55AA55AA);
        chk("after_drain_stall", {31'd0, mem_stall}, 32'd0);
        tick();
        bus_idle();
        tick();

        // Flush and data_ok in the same WAIT cycle -> IDLE, next access issues at once
        set_instr(3'd4, 32'h100, 32'h0);
        data_sram_addr_ok = 1;
        tick();
        data_sram_addr_ok = 0; data_sram_data_ok = 1; flush = 1; data_sram_rdata = 32'h22222222;
        sample();
        chk("fl_dok_stall", {31'd0, mem_stall}, 32'd0);
        tick();
        flush = 0; data_sram_data_ok = 0;
        set_instr(3'd4, 32'h104, 32'h0);
        sample();
        chk("fl_dok_next_req", {31'd0, data_sram_req}, 32'd1);
        chk("fl_dok_next_dm", dm_rdata, 32'd0);
        data_sram_addr_ok = 1;
        tick();
        data_sram_addr_ok = 0; data_sram_data_ok = 1; data_sram_rdata = 32'h33333333; mem_adv = 1;
        sample();
        chk("fl_dok_next_data", dm_rdata, 32'h33333333);
        tick();
        bus_idle();
        tick();

        // Flush in REQ withdraws the request
        set_instr(3'd4, 32'h100, 32'h0);
        tick();
        flush = 1;
        sample();
        chk("req_fl_req", {31'd0, data_sram_req}, 32'd0);
        tick();
        bus_idle();
        sample();
        chk("req_fl_idle_req", {31'd0, data_sram_req}, 32'd0);
        tick();

        // Reset while in WAIT, then a late data_ok is ignored
        set_instr(3'd4, 32'h100, 32'h0);
        data_sram_addr_ok = 1;
        tick();
        bus_idle();
        rst = 1;
        tick();
        rst = 0;
        data_sram_data_ok = 1; data_sram_rdata = 32'hFFFFFFFF;
        sample();
        chk("rstw_req", {31'd0, data_sram_req}, 32'd0);
        chk("rstw_dm", dm_rdata, 32'd0);
        chk("rstw_stall", {31'd0, mem_stall}, 32'd0);
        tick();
        bus_idle();
        sample();
        chk("rstw_dm2", dm_rdata, 32'd0);
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_dsram_master.md
# mem_dsram_master

Memory-stage master for the data SRAM-like interface (req/addr_ok/data_ok) of the pipelined MIPS core. Takes the load/store issued by the EX/MEM register, checks alignment, and drives the request. It tracks the outstanding transaction and produces the extended load data that the MEM/WB register captures as its DM input. It stalls the pipeline while an access is in flight and safely drains a transaction orphaned by an exception flush.

## Interface
- No parameters.
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- flush  in  1  exception flush of MEM stage (same signal as MEM/WB flush)
- mem_en  in  1  instruction in MEM is a load/store
- mem_op  in  3  0 LB, 1 LBU, 2 LH, 3 LHU, 4 LW, 5 SB, 6 SH, 7 SW
- mem_addr  in  32  effective byte address
- mem_wdata  in  32  store data (rt), right-aligned
- mem_adv  in  1  MEM→WB register loads new values this cycle
- data_sram_req  out  1  request valid
- data_sram_wr  out  1  1 = store
- data_sram_size  out  2  0 byte, 1 half, 2 word
- data_sram_addr  out  32  byte address (low bits intact)
- data_sram_wstrb  out  4  byte enables for stores, 0 for loads
- data_sram_wdata  out  32  lane-replicated store data
- data_sram_addr_ok  in  1  request accepted
- data_sram_data_ok  in  1  read data / write ack returned
- data_sram_rdata  in  32  read data
- dm_rdata  out  32  extended load result toward MEM/WB
- mem_stall  out  1  hold IF..MEM stages
- exc_adel  out  1  load address error
- exc_ades  out  1  store address error

## Operation
- States: IDLE, REQ, WAIT, HOLD, DRAIN.
- Misalign: LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0. exc_adel/exc_ades = mem_en & misalign & load/store, combinational, independent of state. No request is ever issued for a misaligned access.
- issue = IDLE & mem_en & ~misalign & ~flush.
- data_sram_req = issue | (REQ & ~flush). Address, size, wr, wstrb and wdata come from the mem_* inputs, which stay stable while stalled.
- wstrb: SB → 4'b0001 << addr[1:0]; SH → 4'b0011 << addr[1:0]; SW → 4'b1111; loads → 0.
- wdata: SB → {4{b}}, SH → {2{h}}, SW → word.
- Transitions:
  - IDLE: issue & addr_ok → WAIT; issue & ~addr_ok → REQ.
  - REQ: flush → IDLE (request withdrawn; the bridge tolerates withdrawal before addr_ok); addr_ok → WAIT.
  - WAIT: data_ok & ~flush & mem_adv → IDLE; data_ok & ~flush & ~mem_adv → HOLD, capturing raw rdata; flush & ~data_ok → DRAIN; flush & data_ok → IDLE with the response discarded.
  - HOLD: mem_adv | flush → IDLE.
  - DRAIN: data_ok → IDLE.
- Captured on issue: addr[1:0] and op, held as the load-extension context.
- Extension is selected by the captured addr[1:0] and op.
  - Byte: lane addr[1:0]; sign-extend for LB, zero-extend for LBU.
  - Half: lane addr[1]; sign-extend for LH, zero-extend for LHU.
  - Word: unchanged.
- dm_rdata source: extended data_sram_rdata in WAIT on data_ok; extended captured rdata in HOLD; 0 otherwise and for stores.
- mem_stall:
  - 1 when mem_en & ~misalign & ~flush & ~((WAIT & data_ok) | HOLD).
  - 1 in DRAIN when mem_en (new access blocked until the orphan response returns).
  - 0 otherwise.
- Single outstanding transaction; no new request while in WAIT, HOLD or DRAIN.

## Timing
- Reset: state IDLE, captured context and rdata 0. The req output is 0 in the cycle after rst is sampled. dm_rdata is 0.
- Best case: req in cycle 0 with addr_ok; data_ok in cycle 1; dm_rdata valid and stall low in cycle 1. MEM/WB captures at the end of cycle 1, so the instruction spends 2 cycles in MEM.
- Each cycle addr_ok is late adds one REQ cycle. Each cycle data_ok is late adds one WAIT cycle.
- addr_ok and data_ok are both ignored outside REQ/IDLE-issue and WAIT/DRAIN respectively.
- Reset mid-transaction: returns to IDLE immediately, with no drain. Any data_ok arriving after that is ignored in IDLE.
- flush and data_ok in the same WAIT cycle: the response is consumed and discarded, and the next state is IDLE.

## Test plan
- LW to 0x100, addr_ok in cycle 0, data_ok in cycle 1 with rdata 0xDEADBEEF, mem_adv=1 → req for 1 cycle, size 2, wstrb 0; stall=1 in cycle 0, 0 in cycle 1; dm_rdata=0xDEADBEEF in cycle 1.
- LB/LBU at addr 0x103 with rdata 0x80FF_7F01 → LB gives 0xFFFFFF80, LBU gives 0x00000080. LH at 0x102 gives 0xFFFF80FF.
- SB 0xAB at 0x201 → wstrb 4'b0010, wdata 0xABABABAB, wr=1; dm_rdata=0. SH at 0x203 → exc_ades=1, req never asserted, stall=0.
- addr_ok delayed 3 cycles, data_ok 2 cycles after that, mem_adv=0 on data_ok → state HOLD. dm_rdata stays at the extended value and stall=0 until mem_adv, then IDLE.
- flush in WAIT before data_ok, next instruction LW → DRAIN and stall=1, with no req. Stale data_ok → IDLE, after which the new LW req is issued.
- rst asserted in WAIT → req=0, state IDLE. A subsequent data_ok is ignored, and dm_rdata=0.
